// File: rtl/pipe_add_sub.sv
// Segmented-carry pipelined adder/subtractor with valid/ready flow control and a global stall.
// Define PIPE_ADD_SUB_SAT_EN to saturate the result on signed overflow instead of wrapping.
module pipe_add_sub #(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int W = N / SEG;

  // Stage k holds the full operands plus the sum bits resolved so far;
  // only segment k+1 upward of the operands is still consumed downstream.
  logic [N-1:0] a_q [SEG];
  logic [N-1:0] b_q [SEG];
  logic [N-1:0] s_q [SEG];
  logic         c_q [SEG];
  logic         v_q [SEG];
  logic         ovf_q;

  logic [N-1:0] a_i [SEG];
  logic [N-1:0] b_i [SEG];
  logic [N-1:0] s_i [SEG];
  logic         c_i [SEG];
  logic         v_i [SEG];
  logic [N-1:0] s_d [SEG];
  logic         c_d [SEG];
  logic [W:0]   seg_sum [SEG];
  logic         ovf_d;
  logic         adv;

  assign out_valid = v_q[SEG-1];
  assign sum       = s_q[SEG-1];
  assign cout      = c_q[SEG-1];
  assign ovf       = ovf_q;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Stage inputs: stage 0 takes the ports (b and cin inverted for subtract).
  always_comb begin
    a_i[0] = a;
    b_i[0] = sub ? ~b : b;
    s_i[0] = '0;
    c_i[0] = sub ? ~cin : cin;
    v_i[0] = in_valid;
    for (int unsigned k = 1; k < SEG; k++) begin
      a_i[k] = a_q[k-1];
      b_i[k] = b_q[k-1];
      s_i[k] = s_q[k-1];
      c_i[k] = c_q[k-1];
      v_i[k] = v_q[k-1];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < SEG; k++) begin
      seg_sum[k] = {1'b0, a_i[k][k*W +: W]} + {1'b0, b_i[k][k*W +: W]}
                 + {{W{1'b0}}, c_i[k]};
      s_d[k]            = s_i[k];
      s_d[k][k*W +: W]  = seg_sum[k][W-1:0];
      c_d[k]            = seg_sum[k][W];
    end
    ovf_d = (a_i[SEG-1][N-1] == b_i[SEG-1][N-1]) &&
            (s_d[SEG-1][N-1] != a_i[SEG-1][N-1]);
`ifdef PIPE_ADD_SUB_SAT_EN
    if (ovf_d)
      s_d[SEG-1] = a_i[SEG-1][N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < SEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < SEG; k++) begin
        a_q[k] <= a_i[k];
        b_q[k] <= b_i[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_i[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipe_add_sub.sv
// Self-checking bench for pipe_add_sub (N=16, SEG=4): integer-arithmetic scoreboard plus directed literal vectors.
module tb_pipe_add_sub;
  localparam int N   = 16;
  localparam int SEG = 4;

`ifdef PIPE_ADD_SUB_SAT_EN
  localparam logic [N-1:0] POS_OVF_SUM = 16'h7FFF;
  localparam logic [N-1:0] NEG_OVF_SUM = 16'h8000;
`else
  localparam logic [N-1:0] POS_OVF_SUM = 16'h8000;
  localparam logic [N-1:0] NEG_OVF_SUM = 16'h7FFF;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [N-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  res_t exp_q[$];

  pipe_add_sub #(.N(N), .SEG(SEG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Result from plain integer arithmetic: unsigned value gives sum/cout, signed value gives ovf.
  function automatic res_t model(input logic [N-1:0] fa, input logic [N-1:0] fb,
                                 input logic fsub, input logic fcin);
    res_t   m;
    longint ua = longint'(fa);
    longint ub = longint'(fb);
    longint sa = longint'($signed(fa));
    longint sb = longint'($signed(fb));
    longint ci = longint'(fcin);
    longint smax = (longint'(1) << (N-1)) - 1;
    longint smin = -(longint'(1) << (N-1));
    longint r, sr;
    if (fsub) begin
      r   = ua - ub - ci;
      sr  = sa - sb - ci;
      m.c = (r >= 0);
    end else begin
      r   = ua + ub + ci;
      sr  = sa + sb + ci;
      m.c = (r >= (longint'(1) << N));
    end
    m.s = N'(r);
    m.o = (sr > smax) || (sr < smin);
`ifdef PIPE_ADD_SUB_SAT_EN
    if (sr > smax) m.s = N'(smax);
    if (sr < smin) m.s = N'(smin);
`endif
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub, cin));
    end
  end

  res_t held;
  logic stalled = 1'b0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_out", {31'b0, out_valid}, 32'd0);
        else check("scoreboard", {14'b0, sum, cout, ovf}, {14'b0, exp_q[0]});
        if (stalled) check("stall_hold", {14'b0, sum, cout, ovf}, {14'b0, held});
      end
      stalled = out_valid && !out_ready;
      held    = {sum, cout, ovf};
    end
  end

  task automatic one_beat(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic tsub, input logic tcin,
                          input logic [N-1:0] es, input logic ec, input logic eo);
    @(negedge clk);
    a = ta; b = tb; sub = tsub; cin = tcin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < SEG - 1; i++) begin
      check({name, "_early"}, {31'b0, out_valid}, 32'd0);
      @(negedge clk);
    end
    check({name, "_lat"},  {31'b0, out_valid}, 32'd1);
    check({name, "_sum"},  {16'b0, sum}, {16'b0, es});
    check({name, "_cout"}, {31'b0, cout}, {31'b0, ec});
    check({name, "_ovf"},  {31'b0, ovf}, {31'b0, eo});
  endtask

  logic [N-1:0] ta_tbl [8] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000,
                               16'h1234, 16'hABCD, 16'h0000, 16'h5555};
  logic [N-1:0] tb_tbl [8] = '{16'h0002, 16'h0001, 16'h7FFF, 16'h0001,
                               16'h4321, 16'h1111, 16'h0000, 16'hAAAA};
  logic         ts_tbl [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic         tc_tbl [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    logic [15:0]  vb;
    logic [N-1:0] saved;

    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'b0, in_ready}, 32'd1);
    check("rst_sum",       {16'b0, sum}, 32'd0);
    check("rst_flags",     {30'b0, cout, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    one_beat("add",        16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2234, 1'b0, 1'b0);
    one_beat("sub_borrow", 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    one_beat("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, POS_OVF_SUM, 1'b0, 1'b1);
    one_beat("ripple",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    one_beat("neg_ovf",    16'h8000, 16'h0001, 1'b1, 1'b0, NEG_OVF_SUM, 1'b1, 1'b1);
    one_beat("sub_bin",    16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);

    // 8 back-to-back beats, full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vb[i] = out_valid;
      if (i < 8) begin
        a = ta_tbl[i]; b = tb_tbl[i]; sub = ts_tbl[i]; cin = tc_tbl[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    check("burst_valid_pattern", {16'b0, vb}, 32'h0000_0FF0);

    // fill, then stall 3 cycles while offering a beat that must wait
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = N'(i + 1); b = N'(2 * i + 2); sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    check("stall_first_valid", {31'b0, out_valid}, 32'd1);
    check("stall_first_sum",   {16'b0, sum}, 32'h0003);
    saved = sum;
    a = 16'h0100; b = 16'h0200; in_valid = 1'b1; out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_valid",    {31'b0, out_valid}, 32'd1);
      check("stall_sum",      {16'b0, sum}, {16'b0, saved});
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("drain_after_stall", exp_q.size(), 32'd0);

    // reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = N'(16'h0010 << i); b = 16'h0001; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", {31'b0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready",  {31'b0, in_ready}, 32'd1);
    check("midrst_outputs",   {14'b0, sum, cout, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_output", {31'b0, out_valid}, 32'd0);
    end

    one_beat("after_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("final_drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
